flexbyte_stp_sr: RTL and testbench

//   Flexible serial-to-parallel multibyte shift register; receive-side counterpart of the

---
 rtl/flexbyte_stp_sr.sv | 125 ++++++++++++
 tb/tb_flexbyte_stp_sr.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flexbyte_stp_sr.sv
// flexbyte_stp_sr
// Serial-to-parallel multibyte shift register. Collects NUM_BYTES_IN-byte chunks
// into a NUM_BYTES_OUT-byte word. Each completed word is copied into a holding
// register and presented to the consumer through a ready/read handshake.
//
// Handshake (word_ready_o / out_read_i):
//   word_ready_o=1 means data_out_o holds a word that has not been read yet.
//   The consumer acknowledges by raising out_read_i for one cycle while
//   word_ready_o=1. That edge clears word_ready_o. An out_read_i pulse while
//   word_ready_o=0 has no effect. The producer side has no backpressure: a word
//   that completes while the previous word is still unread replaces it and
//   sets the sticky overrun_o flag. A word that completes on the same edge as a
//   valid read replaces the read word cleanly and keeps word_ready_o high.
module flexbyte_stp_sr #(
    parameter int MSB           = 1,
    parameter int NUM_BYTES_IN  = 1,
    parameter int NUM_BYTES_OUT = 2,
    localparam int CHUNKS       = NUM_BYTES_OUT / NUM_BYTES_IN,
    localparam int CW           = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       shift_enable,
    input  logic [NUM_BYTES_IN*8-1:0]  data_in,
    input  logic                       clear,
    input  logic                       out_read,
    output logic [NUM_BYTES_OUT*8-1:0] data_out,
    output logic                       word_ready,
    output logic                       overrun,
    output logic [CW-1:0]              chunk_count
);

    localparam int            IW         = NUM_BYTES_IN * 8;
    localparam int            OW         = NUM_BYTES_OUT * 8;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);

    // The word width must be a whole multiple (at least two) of the chunk width.
    if (NUM_BYTES_IN < 1 || NUM_BYTES_OUT <= NUM_BYTES_IN ||
        (NUM_BYTES_OUT % NUM_BYTES_IN) != 0) begin : g_param_check
        $fatal(1, "flexbyte_stp_sr: NUM_BYTES_OUT must exceed and be a multiple of NUM_BYTES_IN");
    end

    // Partial-word shift register and its chunk counter
    logic [OW-1:0] sr_q,   sr_d;
    logic [CW-1:0] cnt_q,  cnt_d;

    // Holding register and handshake flags
    logic [OW-1:0] dout_q, dout_d;
    logic          wr_q,   wr_d;
    logic          ov_q,   ov_d;

    // Shift register contents after absorbing this cycle's data_in
    logic [OW-1:0] sr_shifted;
    logic          last_chunk;
    logic          complete;

    if (MSB != 0) begin : g_msb_first
        // The oldest chunk moves toward the top, so the first chunk ends in the MSBs.
        assign sr_shifted = {sr_q[OW-IW-1:0], data_in};
    end else begin : g_lsb_first
        // The oldest chunk moves toward the bottom, so the first chunk ends in the LSBs.
        assign sr_shifted = {data_in, sr_q[OW-1:IW]};
    end

    assign last_chunk = (cnt_q == LAST_CHUNK);
    assign complete   = shift_enable && last_chunk && !clear;

    // Next-state: clear aborts everything except the holding register;
    // otherwise shift, complete and read are evaluated together.
    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        wr_d   = wr_q;
        ov_d   = ov_q;

        if (clear) begin
            sr_d  = '0;
            cnt_d = '0;
            wr_d  = 1'b0;
            ov_d  = 1'b0;
        end else begin
            if (shift_enable) begin
                sr_d  = sr_shifted;
                cnt_d = last_chunk ? '0 : cnt_q + CW'(1);
            end

            if (complete) begin
                // A new word always wins the holding register. It is an
                // overrun only when the old word was neither read before
                // nor read on this edge.
                dout_d = sr_shifted;
                wr_d   = 1'b1;
                if (wr_q && !out_read) begin
                    ov_d = 1'b1;
                end
            end else if (out_read && wr_q) begin
                wr_d = 1'b0;
            end
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            wr_q   <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            wr_q   <= wr_d;
            ov_q   <= ov_d;
        end
    end

    assign data_out    = dout_q;
    assign word_ready  = wr_q;
    assign overrun     = ov_q;
    assign chunk_count = cnt_q;

endmodule

// File: tb/tb_flexbyte_stp_sr.sv
// Bench for flexbyte_stp_sr. Three instances cover MSB-first 1->2 bytes (a),
// LSB-first 1->2 bytes (b) and MSB-first 2->4 bytes (c). A chunk-list model
// predicts every output each cycle. Directed scenarios add literal checks.
module tb_flexbyte_stp_sr;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance stimulus, index 0=a, 1=b, 2=c
    logic        rst_v [3];
    logic        se_v  [3];
    logic        clr_v [3];
    logic        rd_v  [3];
    logic [15:0] din_v [3];

    logic [15:0] dout_a, dout_b;
    logic [31:0] dout_c;
    logic        wr_a, wr_b, wr_c;
    logic        ov_a, ov_b, ov_c;
    logic        cc_a, cc_b, cc_c;

    int n_vec  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    flexbyte_stp_sr #(.MSB(1), .NUM_BYTES_IN(1), .NUM_BYTES_OUT(2)) u_a (
        .clk(clk), .rst(rst_v[0]), .shift_enable(se_v[0]), .data_in(din_v[0][7:0]),
        .clear(clr_v[0]), .out_read(rd_v[0]), .data_out(dout_a),
        .word_ready(wr_a), .overrun(ov_a), .chunk_count(cc_a)
    );

    flexbyte_stp_sr #(.MSB(0), .NUM_BYTES_IN(1), .NUM_BYTES_OUT(2)) u_b (
        .clk(clk), .rst(rst_v[1]), .shift_enable(se_v[1]), .data_in(din_v[1][7:0]),
        .clear(clr_v[1]), .out_read(rd_v[1]), .data_out(dout_b),
        .word_ready(wr_b), .overrun(ov_b), .chunk_count(cc_b)
    );

    flexbyte_stp_sr #(.MSB(1), .NUM_BYTES_IN(2), .NUM_BYTES_OUT(4)) u_c (
        .clk(clk), .rst(rst_v[2]), .shift_enable(se_v[2]), .data_in(din_v[2]),
        .clear(clr_v[2]), .out_read(rd_v[2]), .data_out(dout_c),
        .word_ready(wr_c), .overrun(ov_c), .chunk_count(cc_c)
    );

    // ---------------- behavioural model ----------------
    function automatic int cfg_msb(input int k);
        return (k == 1) ? 0 : 1;
    endfunction

    function automatic int cfg_nin(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    function automatic int cfg_chunks(input int k);
        return (k == 2) ? 4 / 2 : 2 / 1;
    endfunction

    logic [15:0] m_chunk [3][4];
    int          m_cnt   [3];
    logic [31:0] m_dout  [3];
    logic        m_wr    [3];
    logic        m_ov    [3];
    bit          m_done_a;
    bit          m_done;
    logic [31:0] m_word;
    logic [31:0] exp_q [$];

    // Word = received chunks placed by arrival order at fixed byte offsets
    function automatic logic [31:0] assemble(input int k);
        logic [31:0] w;
        int          sh;
        w = '0;
        for (int i = 0; i < cfg_chunks(k); i++) begin
            if (cfg_msb(k) != 0) sh = (cfg_chunks(k) - 1 - i) * cfg_nin(k) * 8;
            else                 sh = i * cfg_nin(k) * 8;
            w = w | (32'(m_chunk[k][i]) << sh);
        end
        return w;
    endfunction

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_cnt[k]  = 0;
            m_dout[k] = '0;
            m_wr[k]   = 1'b0;
            m_ov[k]   = 1'b0;
        end
        m_done_a = 1'b0;
    end

    always @(posedge clk) begin
        m_done_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (rst_v[k]) begin
                m_cnt[k]  = 0;
                m_dout[k] = '0;
                m_wr[k]   = 1'b0;
                m_ov[k]   = 1'b0;
            end else if (clr_v[k]) begin
                m_cnt[k] = 0;
                m_wr[k]  = 1'b0;
                m_ov[k]  = 1'b0;
            end else begin
                m_done = 1'b0;
                if (se_v[k]) begin
                    m_chunk[k][m_cnt[k]] = (cfg_nin(k) == 2) ? din_v[k] : {8'h00, din_v[k][7:0]};
                    m_cnt[k] = m_cnt[k] + 1;
                    if (m_cnt[k] == cfg_chunks(k)) begin
                        m_word   = assemble(k);
                        m_done   = 1'b1;
                        m_cnt[k] = 0;
                    end
                end
                if (m_done) begin
                    if (m_wr[k] && !rd_v[k]) m_ov[k] = 1'b1;
                    m_dout[k] = m_word;
                    m_wr[k]   = 1'b1;
                    if (k == 0) begin
                        exp_q.push_back(m_word);
                        m_done_a = 1'b1;
                    end
                end else if (rd_v[k] && m_wr[k]) begin
                    m_wr[k] = 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("a_data_out",    32'(dout_a), m_dout[0]);
            check("a_word_ready",  32'(wr_a),   32'(m_wr[0]));
            check("a_overrun",     32'(ov_a),   32'(m_ov[0]));
            check("a_chunk_count", 32'(cc_a),   32'(m_cnt[0]));
            check("b_data_out",    32'(dout_b), m_dout[1]);
            check("b_word_ready",  32'(wr_b),   32'(m_wr[1]));
            check("b_overrun",     32'(ov_b),   32'(m_ov[1]));
            check("b_chunk_count", 32'(cc_b),   32'(m_cnt[1]));
            check("c_data_out",    dout_c,      m_dout[2]);
            check("c_word_ready",  32'(wr_c),   32'(m_wr[2]));
            check("c_overrun",     32'(ov_c),   32'(m_ov[2]));
            check("c_chunk_count", 32'(cc_c),   32'(m_cnt[2]));
            if (m_done_a) begin
                if (exp_q.size() == 0) begin
                    check("a_word_queue_empty", 32'(1), 32'(0));
                end else begin
                    check("a_word_sb", 32'(dout_a), exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int k, input logic se, input logic [15:0] d,
                          input logic clr, input logic rd);
        se_v[k]  = se;
        din_v[k] = d;
        clr_v[k] = clr;
        rd_v[k]  = rd;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) set_in(k, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic shift_a(input logic [7:0] d, input logic rd);
        set_in(0, 1'b1, {8'h00, d}, 1'b0, rd);
        tick();
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [7:0] seq3 [4];
        seq3 = '{8'h11, 8'h22, 8'h33, 8'h44};

        idle_all();
        for (int k = 0; k < 3; k++) rst_v[k] = 1'b1;
        tick();
        tick();
        started = 1'b1;
        check("rst_a_data_out", 32'(dout_a), 32'h0);
        check("rst_a_flags",    {29'd0, wr_a, ov_a, cc_a}, 32'h0);
        check("rst_c_data_out", dout_c, 32'h0);
        for (int k = 0; k < 3; k++) rst_v[k] = 1'b0;

        // Scenarios 1 and 2: 0xAB, 0xCD back-to-back on MSB-first and LSB-first
        set_in(0, 1'b1, 16'h00AB, 1'b0, 1'b0);
        set_in(1, 1'b1, 16'h00AB, 1'b0, 1'b0);
        tick();
        set_in(0, 1'b1, 16'h00CD, 1'b0, 1'b0);
        set_in(1, 1'b1, 16'h00CD, 1'b0, 1'b0);
        tick();
        idle_all();
        check("t1_data_out",    32'(dout_a), 32'hABCD);
        check("t1_word_ready",  32'(wr_a),   32'h1);
        check("t1_chunk_count", 32'(cc_a),   32'h0);
        check("t2_data_out",    32'(dout_b), 32'hCDAB);
        check("t2_word_ready",  32'(wr_b),   32'h1);
        set_in(1, 1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        idle_all();
        check("t2_read_clears", 32'(wr_b),   32'h0);
        check("t2_data_hold",   32'(dout_b), 32'hCDAB);
        // Read with nothing ready must be ignored
        set_in(1, 1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        idle_all();
        tick();

        // Scenario 3: two words unread -> overrun; clear keeps data_out
        set_in(0, 1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) shift_a(seq3[i], 1'b0);
        idle_all();
        check("t3_data_out",   32'(dout_a), 32'h3344);
        check("t3_word_ready", 32'(wr_a),   32'h1);
        check("t3_overrun",    32'(ov_a),   32'h1);
        set_in(0, 1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        idle_all();
        check("t3_clr_overrun", 32'(ov_a),   32'h0);
        check("t3_clr_ready",   32'(wr_a),   32'h0);
        check("t3_clr_data",    32'(dout_a), 32'h3344);

        // Scenario 4: completion coincides with a read of the previous word
        shift_a(8'h11, 1'b0);
        shift_a(8'h22, 1'b0);
        idle_all();
        check("t4_first_word", 32'(dout_a), 32'h1122);
        shift_a(8'h55, 1'b0);
        shift_a(8'h66, 1'b1);
        idle_all();
        check("t4_data_out",   32'(dout_a), 32'h5566);
        check("t4_word_ready", 32'(wr_a),   32'h1);
        check("t4_overrun",    32'(ov_a),   32'h0);
        set_in(0, 1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        idle_all();
        check("t4_read_clears", 32'(wr_a), 32'h0);

        // Partial word held while idle, then scenario 5: clear beats shift_enable
        shift_a(8'hAA, 1'b0);
        idle_all();
        repeat (8) tick();
        check("hold_chunk_count", 32'(cc_a), 32'h1);
        set_in(0, 1'b1, 16'h00FF, 1'b1, 1'b0);
        tick();
        idle_all();
        check("t5_clr_count", 32'(cc_a), 32'h0);
        shift_a(8'h12, 1'b0);
        shift_a(8'h34, 1'b0);
        idle_all();
        check("t5_data_out",   32'(dout_a), 32'h1234);
        check("t5_overrun",    32'(ov_a),   32'h0);

        // Scenario 6: 2->4 bytes, reset mid-word (with shift_enable high)
        set_in(2, 1'b1, 16'hDEAD, 1'b0, 1'b0);
        tick();
        idle_all();
        check("t6_mid_count", 32'(cc_c), 32'h1);
        rst_v[2] = 1'b1;
        set_in(2, 1'b1, 16'h5A5A, 1'b0, 1'b0);
        tick();
        rst_v[2] = 1'b0;
        idle_all();
        check("t6_rst_data",  dout_c, 32'h0);
        check("t6_rst_flags", {29'd0, wr_c, ov_c, cc_c}, 32'h0);
        set_in(2, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        tick();
        set_in(2, 1'b1, 16'hCAFE, 1'b0, 1'b0);
        tick();
        idle_all();
        check("t6_data_out",   dout_c, 32'hBEEFCAFE);
        check("t6_word_ready", 32'(wr_c), 32'h1);
        check("t6_flags",      {30'd0, ov_c, cc_c}, 32'h0);
        set_in(2, 1'b1, 16'h1234, 1'b0, 1'b0);
        tick();
        set_in(2, 1'b1, 16'h5678, 1'b0, 1'b0);
        tick();
        idle_all();
        check("t6_second_word", dout_c, 32'h12345678);
        check("t6_overrun",     32'(ov_c), 32'h1);

        repeat (3) tick();
        if (exp_q.size() != 0) check("a_word_queue_left", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
